// File: rtl/inst_fetch_buf.sv
// Two-entry fully associative instruction fetch buffer between the core ROM port
// and a multi-cycle memory bus, with optional next-sequential-word prefetch.
module inst_fetch_buf #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int TAG_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_t;

  state_t            state;
  logic [1:0]        valid;
  logic [TAG_W-1:0]  tag  [2];
  logic [DATA_W-1:0] data [2];
  logic              lru;
  logic              discard;

  logic [TAG_W-1:0]  cur_tag;
  logic [TAG_W-1:0]  nxt_tag;
  logic [1:0]        match;
  logic [1:0]        nxt_match;
  logic              hit;
  logic              victim;
  logic              fill;
  logic              unused_lsb;

  assign cur_tag    = rom_addr_i[ADDR_W-1:2];
  assign nxt_tag    = cur_tag + TAG_W'(1);
  assign unused_lsb = ^rom_addr_i[1:0];

  always_comb begin
    match     = '0;
    nxt_match = '0;
    for (int i = 0; i < 2; i++) begin
      match[i]     = valid[i] && (tag[i] == cur_tag);
      nxt_match[i] = valid[i] && (tag[i] == nxt_tag);
    end
  end

  // Hits are masked during a flush so the core never consumes a word being invalidated.
  assign hit        = rom_ce_i && !flush_i && (|match);
  assign rom_data_o = hit ? (match[0] ? data[0] : data[1]) : '0;
  assign stallreq_o = rom_ce_i && !hit;

  assign victim = match[0] ? 1'b1 : (match[1] ? 1'b0 : lru);
  assign fill   = (state != IDLE) && mem_ack_i && !flush_i && !discard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      lru        <= 1'b0;
      discard    <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      for (int i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (flush_i) valid <= '0;
      if (fill) begin
        valid[victim] <= 1'b1;
        tag[victim]   <= mem_addr_o[ADDR_W-1:2];
        data[victim]  <= mem_data_i;
        lru           <= ~victim;
      end
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (rom_ce_i && !hit) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {cur_tag, 2'b00};
            state      <= FETCH;
          end else if (PREFETCH_EN && hit && !(|nxt_match)) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {nxt_tag, 2'b00};
            state      <= PREFETCH;
          end
        end
        default: begin
          // The bus cannot abort, so a flush only marks the pending word as stale.
          if (flush_i) discard <= 1'b1;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            discard   <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: a bus model with programmable wait states and
// a queue of expected bus request addresses checked as each request appears.
module tb_inst_fetch_buf;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic        flush_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int checks = 0;
  int errors = 0;
  int wait_cycles = 0;
  int cnt = 0;
  logic [31:0] exp_q[$];

  inst_fetch_buf #(.ADDR_W(32), .DATA_W(32), .PREFETCH_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .flush_i(flush_i), .rom_data_o(rom_data_o), .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h34011100 : ((a ^ 32'h5A5A0000) + 32'h1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ce, input logic [31:0] addr, input logic fl);
    @(negedge clk);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    flush_i    = fl;
    #1;
  endtask

  // Bus model: ack after wait_cycles of request; each new request is scored.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end
      if (mem_req_o) begin
        if (cnt == 0) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL bus_unexpected_req observed=%h expected=none", mem_addr_o);
          end
          if (exp_q.size() != 0) chk("bus_req_addr", mem_addr_o, exp_q.pop_front());
        end
        if (cnt >= wait_cycles) begin
          mem_ack_i  = 1'b1;
          mem_data_i = word(mem_addr_o);
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0; flush_i = 1'b0;
    #3 rst = 1'b0;
    // Reset state
    cyc(0, 32'h0, 0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_stall_ce0", {31'b0, stallreq_o}, 32'h0);
    chk("rst_data", rom_data_o, 32'h0);
    cyc(1, 32'h0, 0);
    chk("rst_stall_ce1", {31'b0, stallreq_o}, 32'h1);
    @(negedge clk); rst = 1'b1; rom_ce_i = 1'b0;

    // Demand miss on 0x0, then prefetch of 0x4
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cyc(1, 32'h0, 0);
    chk("t1_c0_stall", {31'b0, stallreq_o}, 32'h1);
    chk("t1_c0_data", rom_data_o, 32'h0);
    chk("t1_c0_req", {31'b0, mem_req_o}, 32'h0);
    cyc(1, 32'h0, 0);
    chk("t1_c1_stall", {31'b0, stallreq_o}, 32'h1);
    chk("t1_c1_req", {31'b0, mem_req_o}, 32'h1);
    cyc(1, 32'h0, 0);
    chk("t1_c2_stall", {31'b0, stallreq_o}, 32'h0);
    chk("t1_c2_data", rom_data_o, 32'h34011100);
    cyc(1, 32'h0, 0);
    chk("t2_pf_req", {31'b0, mem_req_o}, 32'h1);
    chk("t2_pf_addr", mem_addr_o, 32'h4);
    chk("t2_hit_during_pf", {31'b0, stallreq_o}, 32'h0);
    wait_cycles = 3;
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h100);
    cyc(1, 32'h4, 0);
    chk("t2_seq_stall", {31'b0, stallreq_o}, 32'h0);
    chk("t2_seq_data", rom_data_o, word(32'h4));

    // Demand miss on 0x100 behind a slow prefetch of 0x8
    cyc(1, 32'h100, 0);
    chk("t3_pf_addr", mem_addr_o, 32'h8);
    chk("t3_stall_c0", {31'b0, stallreq_o}, 32'h1);
    for (int i = 1; i < 9; i++) begin
      cyc(1, 32'h100, 0);
      chk("t3_stall_hold", {31'b0, stallreq_o}, 32'h1);
      if (i == 4) chk("t3_idle_gap", {31'b0, mem_req_o}, 32'h0);
      if (i == 5) chk("t3_fetch_addr", mem_addr_o, 32'h100);
    end
    wait_cycles = 0;
    exp_q.push_back(32'h104);
    cyc(1, 32'h100, 0);
    chk("t3_hit_stall", {31'b0, stallreq_o}, 32'h0);
    chk("t3_hit_data", rom_data_o, word(32'h100));
    cyc(0, 32'h100, 0);
    chk("ce0_data", rom_data_o, 32'h0);
    chk("ce0_stall", {31'b0, stallreq_o}, 32'h0);

    // Flush, then wrap-around prefetch from 0xFFFFFFFC
    cyc(0, 32'h0, 1);
    exp_q.push_back(32'hFFFFFFFC);
    exp_q.push_back(32'h0);
    cyc(1, 32'hFFFFFFFC, 0);
    chk("t4_miss_after_flush", {31'b0, stallreq_o}, 32'h1);
    cyc(1, 32'hFFFFFFFC, 0);
    cyc(1, 32'hFFFFFFFC, 0);
    chk("t4_hit_data", rom_data_o, word(32'hFFFFFFFC));
    cyc(1, 32'hFFFFFFFC, 0);
    chk("t4_wrap_req", {31'b0, mem_req_o}, 32'h1);
    chk("t4_wrap_addr", mem_addr_o, 32'h0);

    // Flush in the ack cycle discards the fill
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    cyc(1, 32'h200, 0);
    chk("t5_miss", {31'b0, stallreq_o}, 32'h1);
    cyc(1, 32'h200, 1);
    chk("t5_ack_in_flush", {31'b0, mem_ack_i}, 32'h1);
    chk("t5_flush_stall", {31'b0, stallreq_o}, 32'h1);
    cyc(1, 32'h200, 0);
    chk("t5_miss_again", {31'b0, stallreq_o}, 32'h1);
    chk("t5_req_low", {31'b0, mem_req_o}, 32'h0);
    cyc(1, 32'h200, 0);
    chk("t5_refetch_req", {31'b0, mem_req_o}, 32'h1);
    cyc(1, 32'h200, 0);
    chk("t5_hit_data", rom_data_o, word(32'h200));
    cyc(1, 32'h200, 0);

    // Asynchronous reset in the middle of a fetch
    wait_cycles = 5;
    exp_q.push_back(32'h300);
    cyc(1, 32'h300, 0);
    cyc(1, 32'h300, 0);
    chk("t6_req_before_rst", {31'b0, mem_req_o}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_req_dropped", {31'b0, mem_req_o}, 32'h0);
    chk("t6_stall_in_rst", {31'b0, stallreq_o}, 32'h1);
    chk("t6_data_in_rst", rom_data_o, 32'h0);
    wait_cycles = 0;
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("t6_miss_after_rst", {31'b0, stallreq_o}, 32'h1);
    cyc(1, 32'h300, 0);
    chk("t6_refetch_addr", mem_addr_o, 32'h300);
    cyc(1, 32'h300, 0);
    chk("t6_hit_data", rom_data_o, word(32'h300));
    chk("t6_hit_stall", {31'b0, stallreq_o}, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h300, 0);
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
